// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producers, the round-robin mux and one consumer.
//   in_data   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid  N        per-channel beat valid
//   in_last   N        per-channel end-of-packet marker
//   in_ready  N        per-channel accept (mux combinational output)
//   out_data  WIDTH    registered selected data
//   out_valid 1        registered output valid
//   out_ready 1        consumer accept
//   out_sel   SELW     registered source channel index
//   out_last  1        registered copy of the source channel's in_last
// Modports: master = producers/consumer side, slave = mux side.
interface stream_mux_rr_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_sel;
  logic               out_last;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_sel, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_sel, out_last
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel round-robin stream multiplexer with a single registered output
// stage (1 beat/cycle). Optional packet lock when STREAM_MUX_LOCK_EN is
// defined: a channel keeps the grant until it sends a beat with in_last=1.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   mux_if stream_mux_rr_if.slave: in_data/in_valid/in_last/in_ready,
//          out_data/out_valid/out_ready/out_sel/out_last
module stream_mux_rr #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  stream_mux_rr_if.slave mux_if
);
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;
  localparam logic [SELW-1:0] PTR_RST = SELW'(N - 1);

  logic             load_c;
  logic             xfer_c;
  logic             grant_vld_c;
  logic [SELW-1:0]  grant_c;
  logic [WIDTH-1:0] grant_data_c;
  logic             grant_last_c;
  logic [N-1:0]     in_ready_c;

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic             out_last_q,  out_last_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;
`ifdef STREAM_MUX_LOCK_EN
  logic             lock_q,      lock_d;
`endif

  // Round-robin search starting just after the last served channel.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_c     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!grant_vld_c && mux_if.in_valid[SELW'((32'(ptr_q) + k) % N)]) begin
        grant_vld_c = 1'b1;
        grant_c     = SELW'((32'(ptr_q) + k) % N);
      end
    end
`ifdef STREAM_MUX_LOCK_EN
    // Mid-packet: only the owning channel may proceed, even if it is idle.
    if (lock_q) begin
      grant_vld_c = mux_if.in_valid[ptr_q];
      grant_c     = ptr_q;
    end
`endif
  end

  // Select payload of the granted channel.
  always_comb begin
    grant_data_c = '0;
    grant_last_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_c == SELW'(i)) begin
        grant_data_c = mux_if.in_data[i*WIDTH +: WIDTH];
        grant_last_c = mux_if.in_last[i];
      end
    end
  end

  // Output stage next-state and per-channel ready.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    ptr_d       = ptr_q;
`ifdef STREAM_MUX_LOCK_EN
    lock_d      = lock_q;
`endif
    in_ready_c  = '0;

    // Stage can take a beat when empty or draining this cycle.
    load_c = !out_valid_q || mux_if.out_ready;
    xfer_c = load_c && grant_vld_c;

    if (load_c) begin
      if (xfer_c) begin
        out_data_d  = grant_data_c;
        out_sel_d   = grant_c;
        out_last_d  = grant_last_c;
        out_valid_d = 1'b1;
        ptr_d       = grant_c;
`ifdef STREAM_MUX_LOCK_EN
        lock_d      = !grant_last_c;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (!rst && load_c) begin
      if (N == 1) begin
        in_ready_c = '1;
      end else if (grant_vld_c) begin
        in_ready_c = N'(1) << grant_c;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      ptr_q       <= PTR_RST;
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign mux_if.in_ready  = in_ready_c;
  assign mux_if.out_data  = out_data_q;
  assign mux_if.out_valid = out_valid_q;
  assign mux_if.out_sel   = out_sel_q;
  assign mux_if.out_last  = out_last_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr (N=4, WIDTH=8). Inputs change and
// outputs are checked on the falling clock edge.
module tb_stream_mux_rr;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  stream_mux_rr_if #(.N(4), .WIDTH(8)) bus ();

  stream_mux_rr #(.N(4), .WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .mux_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] v_valid [5];
  logic [3:0] v_last  [5];
  logic [3:0] v_rdy   [5];
  logic       v_ov    [5];
  logic [1:0] v_sel   [5];
  logic [7:0] v_data  [5];
  logic       v_olast [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
`ifdef STREAM_MUX_LOCK_EN
    v_valid = '{4'b0110, 4'b0100, 4'b0110, 4'b0110, 4'b0100};
    v_last  = '{4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0100};
    v_rdy   = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
    v_ov    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    v_sel   = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    v_data  = '{8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hC2};
    v_olast = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    v_valid = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
    v_last  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0110};
    v_rdy   = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010};
    v_ov    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    v_sel   = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    v_data  = '{8'hB1, 8'hC2, 8'hB1, 8'hC2, 8'hB1};
    v_olast = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

    // Reset state, with every channel requesting.
    rst           = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.in_data   = '0;
    bus.in_last   = 4'b1111;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_data",  32'(bus.out_data),  32'(0));
    chk("rst_sel",   32'(bus.out_sel),   32'(0));
    chk("rst_last",  32'(bus.out_last),  32'(0));
    chk("rst_ready", 32'(bus.in_ready),  32'(0));

    // Two channels alternate, channel 0 first.
    @(negedge clk);
    rst          = 1'b0;
    bus.in_data  = {8'h00, 8'hC2, 8'h00, 8'hA0};
    bus.in_valid = 4'b0101;
    #1 chk("alt_ready0", 32'(bus.in_ready), 32'(4'b0001));
    @(negedge clk);
    chk("alt_valid0", 32'(bus.out_valid), 32'(1));
    chk("alt_data0",  32'(bus.out_data),  32'(8'hA0));
    chk("alt_sel0",   32'(bus.out_sel),   32'(0));
    chk("alt_ready1", 32'(bus.in_ready),  32'(4'b0100));
    @(negedge clk);
    chk("alt_data1",  32'(bus.out_data),  32'(8'hC2));
    chk("alt_sel1",   32'(bus.out_sel),   32'(2));
    @(negedge clk);
    chk("alt_data2",  32'(bus.out_data),  32'(8'hA0));
    chk("alt_sel2",   32'(bus.out_sel),   32'(0));

    // Idle: valid drops, data/sel hold, pointer stays on channel 0.
    bus.in_valid = 4'b0000;
    @(negedge clk);
    chk("idle_valid", 32'(bus.out_valid), 32'(0));
    chk("idle_data",  32'(bus.out_data),  32'(8'hA0));
    chk("idle_sel",   32'(bus.out_sel),   32'(0));
    bus.in_valid = 4'b0101;
    @(negedge clk);
    chk("idle_ptr_sel", 32'(bus.out_sel), 32'(2));

    // Channel 3 only, then all four channels rotate.
    bus.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.in_valid = 4'b1000;
    @(negedge clk);
    chk("solo3_sel",  32'(bus.out_sel),  32'(3));
    chk("solo3_data", 32'(bus.out_data), 32'(8'h13));
    bus.in_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rr_valid", 32'(bus.out_valid), 32'(1));
      chk("rr_sel",   32'(bus.out_sel),   32'(k % 4));
      chk("rr_data",  32'(bus.out_data),  32'(8'h10 + k % 4));
    end

    // Backpressure holds out_data=11/sel=1 for three cycles.
    bus.out_ready = 1'b0;
    #1 chk("bp_ready_first", 32'(bus.in_ready), 32'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'(1));
      chk("bp_data",  32'(bus.out_data),  32'(8'h11));
      chk("bp_sel",   32'(bus.out_sel),   32'(1));
      chk("bp_ready", 32'(bus.in_ready),  32'(0));
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.in_ready), 32'(4'b0100));
    @(negedge clk);
    chk("bp_release_data", 32'(bus.out_data), 32'(8'h12));
    chk("bp_release_sel",  32'(bus.out_sel),  32'(2));

    // Asynchronous reset mid-stream, last served channel 2.
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'(0));
    chk("arst_data",  32'(bus.out_data),  32'(0));
    chk("arst_ready", 32'(bus.in_ready),  32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_rel_ready", 32'(bus.in_ready), 32'(4'b0001));
    @(negedge clk);
    chk("arst_rel_valid", 32'(bus.out_valid), 32'(1));
    chk("arst_rel_sel",   32'(bus.out_sel),   32'(0));
    chk("arst_rel_data",  32'(bus.out_data),  32'(8'h10));

    // Channel 1 sends a 3-beat packet while channel 2 is also valid.
    bus.in_data = {8'h00, 8'hC2, 8'hB1, 8'h00};
    for (int j = 0; j < 5; j++) begin
      bus.in_valid = v_valid[j];
      bus.in_last  = v_last[j];
      #1 chk("pkt_ready", 32'(bus.in_ready), 32'(v_rdy[j]));
      @(negedge clk);
      chk("pkt_valid", 32'(bus.out_valid), 32'(v_ov[j]));
      chk("pkt_sel",   32'(bus.out_sel),   32'(v_sel[j]));
      chk("pkt_data",  32'(bus.out_data),  32'(v_data[j]));
      chk("pkt_last",  32'(bus.out_last),  32'(v_olast[j]));
    end

    // Final idle cycle keeps the last data.
    bus.in_valid = 4'b0000;
    @(negedge clk);
    chk("end_valid", 32'(bus.out_valid), 32'(0));
    chk("end_data",  32'(bus.out_data),  32'(v_data[4]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel streaming multiplexer. It is the sequential successor to the fixed 2:1 and 4:1 gate-level muxes.
- Per-channel valid/ready inputs are selected by a round-robin arbiter. The chosen beat is registered into a single output stage with its own valid/ready handshake.
- Sits between multiple producer blocks and one shared downstream consumer, for example a shared bus or FIFO write port.

Parameters:
- N, 4, number of input channels (N >= 1).
- WIDTH, 8, data width per channel in bits.
- SELW, derived: $clog2(N), or 1 when N == 1. Width of the selected-channel index. Not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel beat valid.
- in_last  input  N  per-channel end-of-packet marker. Only used when STREAM_MUX_LOCK_EN is defined; always captured into out_last.
- in_ready  output  N  per-channel accept. Combinational from arbiter state, in_valid, out_valid and out_ready.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream accept.
- out_sel  output  SELW  registered index of the channel that produced out_data.
- out_last  output  1  registered copy of the selected channel's in_last.

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - Round-robin pointer ptr=N-1, so channel 0 has first priority after reset.
  - lock=0 (lock register exists only with STREAM_MUX_LOCK_EN).
  - in_ready is all-zero while rst is high.
- Load enable: load = !out_valid || out_ready. The output stage accepts a new beat in the same cycle the old one drains, giving full throughput of 1 beat/cycle.
- Arbitration (combinational):
  - Search channels starting at (ptr+1) mod N, wrapping.
  - The first channel with in_valid=1 is the grant g. No valid channel means no grant.
- Handshake:
  - in_ready[i] = load && (a grant exists) && (i == g).
  - At most one in_ready bit is high per cycle.
  - A channel transfer occurs when in_valid[i] && in_ready[i].
- On a transfer from channel g, at the clock edge:
  - out_data <= in_data[g], out_sel <= g, out_last <= in_last[g], out_valid <= 1.
  - ptr <= g.
- Load with no grant: out_valid <= 0, and data/sel/last hold their previous values.
- No load (out_valid && !out_ready): all output registers and ptr hold. The output is stable under backpressure.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1.
- Fairness: with all N channels continuously valid and out_ready=1, grants rotate 0,1,...,N-1,0,... Each channel is served once every N beats.
- A single active channel is served every cycle; it is not forced to wait for other channels.
- N == 1: no arbitration; in_ready[0]=load; out_sel is constant 0.
- in_valid may drop without handshake completing. The arbiter re-evaluates every cycle, and no state changes without a transfer.
- rst asserted mid-stream: any in-flight output beat is discarded. No partial state survives.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN.
- Defined — packet lock:
  - After a transfer from g with in_last[g]=0, lock <= 1 and the grant is pinned to ptr.
  - While locked, only channel ptr can be granted. Other channels see in_ready=0 even if the locked channel is idle.
  - A transfer with in_last=1 clears lock, and round-robin resumes from ptr+1.
  - Reset clears lock.
- Undefined: no lock register; arbitration is per beat; in_last is only passed through to out_last.

Test Plan (N=4, WIDTH=8):
- Reset, then in_valid=4'b0101 with ch0=8'hA0, ch2=8'hC2, out_ready=1 → cycle+1 out_data=A0/out_sel=0; cycle+2 C2/sel=2; cycle+3 A0/sel=0 (alternation).
- All four channels valid with data 8'h10..8'h13, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3; out_valid high continuously.
- Backpressure: out_valid=1 with out_data=8'h11, hold out_ready=0 for 3 cycles → out_data/out_sel unchanged, in_ready=4'b0000; then out_ready=1 → next grant takes over in the same cycle.
- Assert rst asynchronously mid-stream with out_valid=1 → out_valid drops before the next clk edge; after release, the first grant goes to channel 0 even if channel 3 was last served.
- STREAM_MUX_LOCK_EN: ch1 sends 3 beats (last on beat 3) while ch2 is valid → out_sel 1,1,1 then 2. Without the macro, the same stimulus gives 1,2,1,2,1.
- Idle: in_valid=0 with out_ready=1 → out_valid=0 next cycle, out_data holds its last value, ptr unchanged.
